// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// riscv_pkg / lsu_mem_ctrl
//
// Load/store unit back end. One decoded memory operation is accepted from the
// execute stage, turned into a single doubleword-aligned data-memory access,
// and the aligned, extended load data (or a store completion) is handed to
// writeback. Blocking: one operation in flight at a time.
//
// Ports
//   clk, rst_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready         execute -> LSU handshake
//   req_op, req_addr,
//   req_wdata, req_rd           decoded operation, byte address, store data, rd tag
//   resp_valid/resp_ready       LSU -> writeback handshake
//   resp_rdata, resp_rd,
//   resp_err                    extended load data, echoed rd, error flag
//   mem_req_valid/mem_req_ready LSU -> data-memory request handshake
//   mem_we, mem_addr,
//   mem_wdata, mem_wstrb        write flag, doubleword address, lane data, strobes
//   mem_rsp_valid, mem_rdata    single-cycle read data / write acknowledge
// -----------------------------------------------------------------------------

package riscv_pkg;

    localparam int XLEN = 64;

    // Encodings 12..15 are unused and treated as illegal by the LSU.
    typedef enum logic [3:0] {
        LSU_NONE = 4'd0,
        LSU_LB   = 4'd1,
        LSU_LH   = 4'd2,
        LSU_LW   = 4'd3,
        LSU_LD   = 4'd4,
        LSU_LBU  = 4'd5,
        LSU_LHU  = 4'd6,
        LSU_LWU  = 4'd7,
        LSU_SB   = 4'd8,
        LSU_SH   = 4'd9,
        LSU_SW   = 4'd10,
        LSU_SD   = 4'd11
    } lsu_op_t;

endpackage

module lsu_mem_ctrl
    import riscv_pkg::*;
#(
    parameter int ADDR_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_err,

    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [7:0]        mem_wstrb,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MREQ  = 2'd1,
        MWAIT = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    // ------------------------------------------------------------------
    // Decode of the operation currently presented by the execute stage
    // ------------------------------------------------------------------
    logic [1:0] size_log2;     // 0 = byte, 1 = half, 2 = word, 3 = double
    logic       is_load;
    logic       is_store;
    logic       illegal;
    logic       misaligned;
    logic       needs_bus;
    logic       accept;

    always_comb begin
        size_log2 = 2'd0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        case (req_op)
            LSU_LB, LSU_LBU: begin size_log2 = 2'd0; is_load  = 1'b1; end
            LSU_LH, LSU_LHU: begin size_log2 = 2'd1; is_load  = 1'b1; end
            LSU_LW, LSU_LWU: begin size_log2 = 2'd2; is_load  = 1'b1; end
            LSU_LD:          begin size_log2 = 2'd3; is_load  = 1'b1; end
            LSU_SB:          begin size_log2 = 2'd0; is_store = 1'b1; end
            LSU_SH:          begin size_log2 = 2'd1; is_store = 1'b1; end
            LSU_SW:          begin size_log2 = 2'd2; is_store = 1'b1; end
            LSU_SD:          begin size_log2 = 2'd3; is_store = 1'b1; end
            default: ;
        endcase
    end

    assign illegal = (req_op >= 4'd12);

    // Byte accesses are never misaligned; wider ones need their low address
    // bits clear. Illegal ops and LSU_NONE decode as size 0, hence never flag.
    always_comb begin
        misaligned = 1'b0;
        case (size_log2)
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            2'd3:    misaligned = |req_addr[2:0];
            default: misaligned = 1'b0;
        endcase
    end

    assign needs_bus = (is_load || is_store) && !misaligned;
    assign accept    = (state_reg == IDLE) && req_valid;

    // ------------------------------------------------------------------
    // Store lane replication and byte strobes, one generate lane per byte.
    // Each lane picks the source byte at (lane mod access size), so the
    // store data appears in every naturally aligned slot of the doubleword
    // and the strobes select the one slot actually written.
    // ------------------------------------------------------------------
    logic [XLEN-1:0] st_wdata;
    logic [7:0]      st_wstrb;
    logic [3:0]      st_span;     // access size in bytes
    logic [3:0]      st_off;      // byte offset within the doubleword

    assign st_span = 4'd1 << size_log2;
    assign st_off  = {1'b0, req_addr[2:0]};

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_lane
            assign st_wdata[gi*8 +: 8] =
                (size_log2 == 2'd0) ? req_wdata[7:0] :
                (size_log2 == 2'd1) ? req_wdata[(gi % 2)*8 +: 8] :
                (size_log2 == 2'd2) ? req_wdata[(gi % 4)*8 +: 8] :
                                      req_wdata[gi*8 +: 8];

            assign st_wstrb[gi] = is_store
                                  && (4'(gi) >= st_off)
                                  && (4'(gi) <  (st_off + st_span));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Held operation context and bus / response registers
    // ------------------------------------------------------------------
    logic [3:0]        op_reg;
    logic [2:0]        off_reg;
    logic              mem_we_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [XLEN-1:0]   mem_wdata_reg;
    logic [7:0]        mem_wstrb_reg;
    logic [XLEN-1:0]   resp_rdata_reg;
    logic [4:0]        resp_rd_reg;
    logic              resp_err_reg;

    // ------------------------------------------------------------------
    // Load data alignment and extension
    // ------------------------------------------------------------------
    logic [XLEN-1:0] ld_shifted;
    logic [XLEN-1:0] ld_result;

    assign ld_shifted = mem_rdata >> {off_reg, 3'b000};

    // Stores fall through to the default and complete with zero data.
    always_comb begin
        ld_result = '0;
        case (op_reg)
            LSU_LB:  ld_result = {{(XLEN-8){ld_shifted[7]}},   ld_shifted[7:0]};
            LSU_LH:  ld_result = {{(XLEN-16){ld_shifted[15]}}, ld_shifted[15:0]};
            LSU_LW:  ld_result = {{(XLEN-32){ld_shifted[31]}}, ld_shifted[31:0]};
            LSU_LD:  ld_result = ld_shifted;
            LSU_LBU: ld_result = {{(XLEN-8){1'b0}},  ld_shifted[7:0]};
            LSU_LHU: ld_result = {{(XLEN-16){1'b0}}, ld_shifted[15:0]};
            LSU_LWU: ld_result = {{(XLEN-32){1'b0}}, ld_shifted[31:0]};
            default: ld_result = '0;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Handshake outputs come straight from the state so they are glitch-free
    // registered decodes; there is no bypass from RESP back to a new accept.
    always_comb begin
        state_next    = state_reg;
        req_ready     = 1'b0;
        mem_req_valid = 1'b0;
        resp_valid    = 1'b0;
        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = needs_bus ? MREQ : RESP;
                end
            end
            MREQ: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_next = MWAIT;
                end
            end
            MWAIT: begin
                if (mem_rsp_valid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers. Request fields are captured once at accept and
    // stay untouched through MREQ, so they are stable while the bus stalls.
    // Response fields are written at accept (no-bus paths) or when the
    // memory answers, and then held through RESP.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_reg         <= 4'd0;
            off_reg        <= 3'd0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_wstrb_reg  <= 8'd0;
            resp_rdata_reg <= '0;
            resp_rd_reg    <= 5'd0;
            resp_err_reg   <= 1'b0;
        end else begin
            if (accept) begin
                op_reg         <= req_op;
                off_reg        <= req_addr[2:0];
                resp_rd_reg    <= req_rd;
                resp_rdata_reg <= '0;
                resp_err_reg   <= illegal || misaligned;
                if (needs_bus) begin
                    mem_addr_reg  <= {req_addr[ADDR_W-1:3], 3'b000};
                    mem_we_reg    <= is_store;
                    mem_wdata_reg <= is_store ? st_wdata : '0;
                    mem_wstrb_reg <= st_wstrb;
                end
            end
            if ((state_reg == MWAIT) && mem_rsp_valid) begin
                resp_rdata_reg <= ld_result;
                resp_err_reg   <= 1'b0;
            end
        end
    end

    assign mem_we     = mem_we_reg;
    assign mem_addr   = mem_addr_reg;
    assign mem_wdata  = mem_wdata_reg;
    assign mem_wstrb  = mem_wstrb_reg;
    assign resp_rdata = resp_rdata_reg;
    assign resp_rd    = resp_rd_reg;
    assign resp_err   = resp_err_reg;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
//
// Bench for lsu_mem_ctrl. A directed scenario per feature plus a randomized
// run; expected values come from a byte-level model of RISC-V load/store
// semantics written with plain arithmetic.
// -----------------------------------------------------------------------------

module tb_lsu_mem_ctrl;
    import riscv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_op;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [63:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.ADDR_W(64)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_op        (req_op),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_rdata    (resp_rdata),
        .resp_rd       (resp_rd),
        .resp_err      (resp_err),
        .mem_req_valid (mem_req_valid),
        .mem_req_ready (mem_req_ready),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wstrb     (mem_wstrb),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rdata     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Everything observed during one transaction.
    typedef struct {
        logic        saw_req;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  wstrb;
        logic        we;
        int          req_lat;
        logic        saw_resp;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        err;
        int          resp_lat;
        logic        unstable;
        logic        ready_bad;
        logic        ready_after;
        logic        timeout;
    } obs_t;

    // ---------------------------------------------------------------
    // Reference model (architectural view of each op)
    // ---------------------------------------------------------------
    function automatic int op_bytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd5, 4'd8:  return 1;
            4'd2, 4'd6, 4'd9:  return 2;
            4'd3, 4'd7, 4'd10: return 4;
            4'd4, 4'd11:       return 8;
            default:           return 0;
        endcase
    endfunction

    function automatic bit op_signed(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd2) || (op == 4'd3);
    endfunction

    function automatic bit op_is_load(input logic [3:0] op);
        return (op >= 4'd1) && (op <= 4'd7);
    endfunction

    function automatic bit op_is_store(input logic [3:0] op);
        return (op >= 4'd8) && (op <= 4'd11);
    endfunction

    function automatic logic [63:0] model_load(input logic [3:0] op, input logic [63:0] addr,
                                               input logic [63:0] rdata);
        int          n;
        logic [63:0] val;
        logic [63:0] mask;
        n   = op_bytes(op);
        val = rdata >> (8 * int'(addr[2:0]));
        if (n < 8) begin
            mask = (64'd1 << (8 * n)) - 64'd1;
            val  = val & mask;
            if (op_signed(op) && val[8*n-1]) val = val | ~mask;
        end
        return val;
    endfunction

    function automatic logic [63:0] model_wdata(input logic [3:0] op, input logic [63:0] wdata);
        int n;
        n = op_bytes(op);
        case (n)
            1:       return (wdata & 64'hFF)       * 64'h0101_0101_0101_0101;
            2:       return (wdata & 64'hFFFF)     * 64'h0001_0001_0001_0001;
            4:       return (wdata & 64'hFFFF_FFFF) * 64'h0000_0001_0000_0001;
            default: return wdata;
        endcase
    endfunction

    function automatic logic [7:0] model_wstrb(input logic [3:0] op, input logic [63:0] addr);
        int n;
        n = op_bytes(op);
        if (!op_is_store(op)) return 8'h00;
        return 8'(((1 << n) - 1) << int'(addr[2:0]));
    endfunction

    // ---------------------------------------------------------------
    // Transaction driver: presents one op, plays the memory and the
    // writeback stage with the requested stalls, and records what it saw.
    // ---------------------------------------------------------------
    task automatic run_op(input logic [3:0] op, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [4:0] rd, input logic [63:0] rdata, input int req_stall,
                          input int rsp_delay, input int resp_stall, output obs_t o);
        int lat;
        int req_cycles;
        int resp_cycles;
        int rsp_wait;
        int guard;
        bit rsp_pending;
        bit req_done;
        bit done;
        o = '{default: 0};
        req_cycles  = 0;
        resp_cycles = 0;
        rsp_wait    = 0;
        rsp_pending = 0;
        req_done    = 0;
        done        = 0;
        guard       = 0;
        while (req_ready !== 1'b1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid = 1'b1;
        req_op    = op;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        @(negedge clk);
        // Scramble the request bus so only latched values can be correct.
        req_valid = 1'b0;
        req_op    = 4'(LSU_NONE);
        req_addr  = {$urandom, $urandom};
        req_wdata = {$urandom, $urandom};
        req_rd    = 5'($urandom);
        lat = 1;
        while (!done && lat < 60) begin
            mem_rsp_valid = 1'b0;
            mem_rdata     = {$urandom, $urandom};
            if (rsp_pending) begin
                if (rsp_wait == 0) begin
                    mem_rsp_valid = 1'b1;
                    mem_rdata     = rdata;
                    rsp_pending   = 0;
                end else begin
                    rsp_wait--;
                end
            end
            if (req_ready !== 1'b0) o.ready_bad = 1'b1;
            if (mem_req_valid === 1'b1) begin
                if (req_done) o.unstable = 1'b1;
                if (!o.saw_req) begin
                    o.saw_req = 1'b1;
                    o.addr    = mem_addr;
                    o.wdata   = mem_wdata;
                    o.wstrb   = mem_wstrb;
                    o.we      = mem_we;
                    o.req_lat = lat;
                end else if (mem_addr !== o.addr || mem_wdata !== o.wdata ||
                             mem_wstrb !== o.wstrb || mem_we !== o.we) begin
                    o.unstable = 1'b1;
                end
                if (req_cycles >= req_stall && !req_done) begin
                    mem_req_ready = 1'b1;
                    req_done      = 1;
                    rsp_pending   = 1;
                    rsp_wait      = rsp_delay;
                end else begin
                    mem_req_ready = 1'b0;
                end
                req_cycles++;
            end else begin
                mem_req_ready = 1'b0;
                if (o.saw_req && !req_done) o.unstable = 1'b1;
            end
            if (resp_valid === 1'b1) begin
                if (!o.saw_resp) begin
                    o.saw_resp = 1'b1;
                    o.rdata    = resp_rdata;
                    o.rd       = resp_rd;
                    o.err      = resp_err;
                    o.resp_lat = lat;
                end else if (resp_rdata !== o.rdata || resp_rd !== o.rd || resp_err !== o.err) begin
                    o.unstable = 1'b1;
                end
                if (resp_cycles >= resp_stall) begin
                    resp_ready = 1'b1;
                    done       = 1;
                end else begin
                    resp_ready = 1'b0;
                end
                resp_cycles++;
            end else begin
                resp_ready = 1'b0;
            end
            @(negedge clk);
            lat++;
        end
        mem_req_ready = 1'b0;
        resp_ready    = 1'b0;
        mem_rsp_valid = 1'b0;
        o.timeout     = !done;
        o.ready_after = req_ready;
        $display("op=%0d addr=%h rd=%0d -> bus=%0b we=%0b maddr=%h wstrb=%h rdata=%h err=%0b lat=%0d",
                 op, addr, rd, o.saw_req, o.we, o.addr, o.wstrb, o.rdata, o.err, o.resp_lat);
    endtask

    // ---------------------------------------------------------------
    // Scenarios
    // ---------------------------------------------------------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_req_ready got=%b exp=1", req_ready);
        end
        checks++;
        if ({mem_req_valid, resp_valid, mem_we, resp_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000", {mem_req_valid, resp_valid, mem_we, resp_err});
        end
        checks++;
        if ({mem_addr, mem_wdata, mem_wstrb, resp_rdata, resp_rd} !== '0) begin
            errors++;
            $display("FAIL reset_buses addr=%h wdata=%h wstrb=%h rdata=%h rd=%0d exp=0",
                     mem_addr, mem_wdata, mem_wstrb, resp_rdata, resp_rd);
        end
        // A stray memory response while idle must not produce a result.
        mem_rsp_valid = 1'b1;
        mem_rdata     = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        repeat (3) begin
            checks++;
            if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
                errors++;
                $display("FAIL idle_rsp_ignored resp_valid=%b req_ready=%b exp=0/1", resp_valid, req_ready);
            end
            @(negedge clk);
        end
        $display("reset/idle scenario done");
    endtask

    task automatic test_load_extend();
        obs_t o;
        run_op(4'(LSU_LB), 64'h1003, 64'h0, 5'd7, 64'h0000_0000_8000_0000, 0, 0, 0, o);
        checks++;
        if (o.addr !== 64'h1000 || o.wstrb !== 8'h00 || o.we !== 1'b0) begin
            errors++;
            $display("FAIL lb_bus addr=%h wstrb=%h we=%b exp=1000/00/0", o.addr, o.wstrb, o.we);
        end
        checks++;
        if (o.rdata !== 64'hFFFF_FFFF_FFFF_FF80 || o.err !== 1'b0 || o.rd !== 5'd7) begin
            errors++;
            $display("FAIL lb_sext rdata=%h err=%b rd=%0d exp=ffffffffffffff80/0/7", o.rdata, o.err, o.rd);
        end
        checks++;
        if (o.resp_lat !== 3 || o.req_lat !== 1) begin
            errors++;
            $display("FAIL lb_latency resp_lat=%0d req_lat=%0d exp=3/1", o.resp_lat, o.req_lat);
        end
        run_op(4'(LSU_LBU), 64'h1003, 64'h0, 5'd8, 64'h0000_0000_8000_0000, 0, 0, 0, o);
        checks++;
        if (o.rdata !== 64'h80 || o.err !== 1'b0) begin
            errors++;
            $display("FAIL lbu_zext rdata=%h err=%b exp=80/0", o.rdata, o.err);
        end
    endtask

    task automatic test_store_lanes();
        obs_t o;
        run_op(4'(LSU_SH), 64'h2006, 64'h1234_5678_9ABC_BEEF, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 0, 1, 0, o);
        checks++;
        if (o.addr !== 64'h2000 || o.we !== 1'b1) begin
            errors++;
            $display("FAIL sh_addr addr=%h we=%b exp=2000/1", o.addr, o.we);
        end
        checks++;
        if (o.wdata !== 64'hBEEF_BEEF_BEEF_BEEF || o.wstrb !== 8'hC0) begin
            errors++;
            $display("FAIL sh_lanes wdata=%h wstrb=%h exp=beefbeefbeefbeef/c0", o.wdata, o.wstrb);
        end
        checks++;
        if (!o.saw_resp || o.rdata !== 64'h0 || o.err !== 1'b0 || o.resp_lat !== 4) begin
            errors++;
            $display("FAIL sh_resp seen=%b rdata=%h err=%b lat=%0d exp=1/0/0/4",
                     o.saw_resp, o.rdata, o.err, o.resp_lat);
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(4'(LSU_LW), 64'h3002, 64'h0, 5'd9, 64'h1111_2222_3333_4444, 0, 0, 0, o);
        checks++;
        if (o.saw_req !== 1'b0 || o.err !== 1'b1 || o.rdata !== 64'h0 || o.resp_lat !== 1) begin
            errors++;
            $display("FAIL lw_misaligned bus=%b err=%b rdata=%h lat=%0d exp=0/1/0/1",
                     o.saw_req, o.err, o.rdata, o.resp_lat);
        end
        run_op(4'(LSU_SD), 64'h3004, 64'hABCD, 5'd10, 64'h0, 0, 0, 0, o);
        checks++;
        if (o.saw_req !== 1'b0 || o.err !== 1'b1 || o.rd !== 5'd10) begin
            errors++;
            $display("FAIL sd_misaligned bus=%b err=%b rd=%0d exp=0/1/10", o.saw_req, o.err, o.rd);
        end
        run_op(4'hF, 64'h3000, 64'h0, 5'd11, 64'h0, 0, 0, 0, o);
        checks++;
        if (o.saw_req !== 1'b0 || o.err !== 1'b1 || o.rdata !== 64'h0) begin
            errors++;
            $display("FAIL illegal_op bus=%b err=%b rdata=%h exp=0/1/0", o.saw_req, o.err, o.rdata);
        end
        run_op(4'(LSU_NONE), 64'h3001, 64'h0, 5'd12, 64'h0, 0, 0, 0, o);
        checks++;
        if (o.saw_req !== 1'b0 || o.err !== 1'b0 || o.rdata !== 64'h0 || o.rd !== 5'd12) begin
            errors++;
            $display("FAIL none_op bus=%b err=%b rdata=%h rd=%0d exp=0/0/0/12",
                     o.saw_req, o.err, o.rdata, o.rd);
        end
    endtask

    task automatic test_backpressure();
        obs_t o;
        run_op(4'(LSU_LHU), 64'h5006, 64'h0, 5'd13, 64'h8765_0000_0000_0000, 5, 2, 3, o);
        checks++;
        if (o.unstable !== 1'b0 || o.ready_bad !== 1'b0) begin
            errors++;
            $display("FAIL bp_stable unstable=%b ready_bad=%b exp=0/0", o.unstable, o.ready_bad);
        end
        checks++;
        if (o.resp_lat !== 10 || o.timeout !== 1'b0) begin
            errors++;
            $display("FAIL bp_latency lat=%0d timeout=%b exp=10/0", o.resp_lat, o.timeout);
        end
        checks++;
        if (o.rdata !== 64'h8765 || o.ready_after !== 1'b1) begin
            errors++;
            $display("FAIL bp_result rdata=%h ready_after=%b exp=8765/1", o.rdata, o.ready_after);
        end
    endtask

    task automatic test_abort();
        obs_t o;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 4'(LSU_LD);
        req_addr  = 64'h4000;
        req_wdata = 64'h0;
        req_rd    = 5'd21;
        @(negedge clk);
        req_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        checks++;
        if (req_ready !== 1'b0 || mem_req_valid !== 1'b0 || mem_addr !== 64'h4000) begin
            errors++;
            $display("FAIL abort_in_mwait req_ready=%b mem_req_valid=%b addr=%h exp=0/0/4000",
                     req_ready, mem_req_valid, mem_addr);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
            {mem_addr, mem_wstrb, mem_we, resp_rd, resp_rdata} !== '0) begin
            errors++;
            $display("FAIL abort_reset req_ready=%b resp_valid=%b addr=%h rd=%0d exp=1/0/0/0",
                     req_ready, resp_valid, mem_addr, resp_rd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(4'(LSU_LD), 64'h4000, 64'h0, 5'd22, 64'h0123_4567_89AB_CDEF, 0, 0, 0, o);
        checks++;
        if (o.rdata !== 64'h0123_4567_89AB_CDEF || o.err !== 1'b0 || o.addr !== 64'h4000) begin
            errors++;
            $display("FAIL abort_then_ld rdata=%h err=%b addr=%h exp=0123456789abcdef/0/4000",
                     o.rdata, o.err, o.addr);
        end
    endtask

    task automatic test_random();
        obs_t        o;
        logic [3:0]  op;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        logic [4:0]  rd;
        int          rs;
        int          rw;
        int          ps;
        int          n;
        bit          legal;
        bit          mis;
        bit          bus;
        int          exp_lat;
        logic [63:0] exp_rdata;
        for (int t = 0; t < 60; t++) begin
            op    = 4'($urandom_range(0, 15));
            addr  = {$urandom, $urandom};
            wdata = {$urandom, $urandom};
            rdata = {$urandom, $urandom};
            rd    = 5'($urandom);
            rs    = $urandom_range(0, 2);
            rw    = $urandom_range(0, 2);
            ps    = $urandom_range(0, 2);
            n     = op_bytes(op);
            legal = (op < 4'd12);
            mis   = legal && (n > 1) && ((int'(addr[2:0]) % n) != 0);
            bus   = (op_is_load(op) || op_is_store(op)) && !mis;
            exp_lat   = bus ? (3 + rs + rw) : 1;
            exp_rdata = (bus && op_is_load(op)) ? model_load(op, addr, rdata) : 64'h0;
            run_op(op, addr, wdata, rd, rdata, rs, rw, ps, o);
            checks++;
            if (o.rdata !== exp_rdata || o.err !== (!legal || mis) || o.rd !== rd) begin
                errors++;
                $display("FAIL rand_resp op=%0d addr=%h rdata=%h err=%b rd=%0d exp=%h/%b/%0d",
                         op, addr, o.rdata, o.err, o.rd, exp_rdata, (!legal || mis), rd);
            end
            checks++;
            if (o.saw_req !== bus || o.resp_lat !== exp_lat || o.timeout || o.unstable ||
                o.ready_bad || o.ready_after !== 1'b1) begin
                errors++;
                $display("FAIL rand_flow op=%0d bus=%b lat=%0d to=%b unst=%b rb=%b ra=%b exp bus=%b lat=%0d",
                         op, o.saw_req, o.resp_lat, o.timeout, o.unstable, o.ready_bad,
                         o.ready_after, bus, exp_lat);
            end
            if (bus) begin
                checks++;
                if (o.addr !== (addr & ~64'h7) || o.we !== op_is_store(op) ||
                    o.wstrb !== model_wstrb(op, addr)) begin
                    errors++;
                    $display("FAIL rand_bus op=%0d addr=%h we=%b wstrb=%h exp=%h/%b/%h", op, o.addr,
                             o.we, o.wstrb, addr & ~64'h7, op_is_store(op), model_wstrb(op, addr));
                end
                if (op_is_store(op)) begin
                    checks++;
                    if (o.wdata !== model_wdata(op, wdata)) begin
                        errors++;
                        $display("FAIL rand_wdata op=%0d wdata=%h exp=%h", op, o.wdata, model_wdata(op, wdata));
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        req_valid     = 1'b0;
        req_op        = 4'd0;
        req_addr      = 64'd0;
        req_wdata     = 64'd0;
        req_rd        = 5'd0;
        resp_ready    = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = 64'd0;
        test_reset();
        test_load_extend();
        test_store_lanes();
        test_misaligned();
        test_backpressure();
        test_abort();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
